// File: rtl/logmul_iq_sat.sv
// logmul_iq_sat: I/Q gain scaler by 2^E * M/2^MW with round-half-up and saturation to OW bits
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   dix, diy        signed DW-bit input sample pair
//   iv              input valid, accepted only while rdy=1
//   gain            {E[EW-1:0], M[MW-1:0]}, captured with the samples
//   dox, doy        signed OW-bit scaled outputs, held between updates
//   ov              one-cycle output valid pulse
//   ovf             saturation flag for the pair, updated with ov
//   rdy             idle and able to accept iv
module logmul_iq_sat #(
   parameter int DW = 20,
   parameter int OW = 16,
   parameter int EW = 4,
   parameter int MW = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] dix,
   input  logic signed [DW-1:0] diy,
   input  logic                 iv,
   input  logic [EW+MW-1:0]     gain,
   output logic signed [OW-1:0] dox,
   output logic signed [OW-1:0] doy,
   output logic                 ov,
   output logic                 ovf,
   output logic                 rdy
);
   localparam int PW = DW + MW + 1;
   localparam int SW = DW + MW + (1 << EW);
   localparam int K  = DW + MW - OW;
   localparam int RW = SW - K;

   typedef enum logic [1:0] {idle, mulx, muly, rnd} state_t;

   state_t state, nxt;
   logic signed [DW-1:0] cx, cy, a;
   logic [EW-1:0] e;
   logic [MW-1:0] m;
   logic signed [PW-1:0] a_ext, m_ext, prod, px, py;
   logic signed [OW-1:0] rx;
   logic ovx, cap, ldx, ldy, ldo;
   logic [OW:0] sx, sy;

   // returns {saturated, value}; in range when all bits above the OW-bit result agree
   function automatic logic [OW:0] rnd_sat(input logic signed [PW-1:0] p, input logic [EW-1:0] sh);
      logic signed [SW-1:0] s;
      logic signed [RW-1:0] r;
      logic fit;
      s = {{(SW-PW){p[PW-1]}}, p};
      s = (s <<< sh) + (SW'(1) << (K-1));
      r = RW'(s >>> K);
      fit = (&r[RW-1:OW-1]) | (~|r[RW-1:OW-1]);
      return fit ? {1'b0, r[OW-1:0]} : {1'b1, r[RW-1], {(OW-1){~r[RW-1]}}};
   endfunction

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= idle;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         idle:    nxt = iv ? mulx : idle;
         mulx:    nxt = muly;
         muly:    nxt = rnd;
         default: nxt = idle;
      endcase
   end

   always_comb begin
      cap = state == idle && iv;
      ldx = state == mulx;
      ldy = state == muly;
      ldo = state == rnd;
   end

   // single shared multiplier: X operand in mulx, Y operand in muly
   always_comb begin
      a     = ldy ? cy : cx;
      a_ext = {{(MW+1){a[DW-1]}}, a};
      m_ext = {{(DW+1){1'b0}}, m};
      prod  = a_ext * m_ext;
      sx    = rnd_sat(px, e);
      sy    = rnd_sat(py, e);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {cx, cy, e, m} <= '0;
         {px, py, rx, ovx} <= '0;
         {dox, doy, ov, ovf} <= '0;
         rdy <= 1'b1;
      end else begin
         rdy <= nxt == idle;
         ov  <= ldo;
         if (cap) {cx, cy, e, m} <= {dix, diy, gain};
         if (ldx) px <= prod;
         if (ldy) begin
            py <= prod;
            {ovx, rx} <= sx;
         end
         if (ldo) begin
            dox <= rx;
            doy <= sy[OW-1:0];
            ovf <= ovx | sy[OW];
         end
      end
endmodule

// File: tb/tb_logmul_iq_sat.sv
// tb_logmul_iq_sat: directed self-checking bench for logmul_iq_sat
module tb_logmul_iq_sat;
   logic clk = 1'b0, rst = 1'b1, iv = 1'b0;
   logic signed [19:0] dix = '0, diy = '0;
   logic [15:0] gain = '0;
   logic signed [15:0] dox, doy;
   logic ov, ovf, rdy;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   logmul_iq_sat dut (
      .clk(clk), .rst(rst), .dix(dix), .diy(diy), .iv(iv), .gain(gain),
      .dox(dox), .doy(doy), .ov(ov), .ovf(ovf), .rdy(rdy)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic void ref_iq(input int d, input logic [15:0] g, output int r, output bit sat);
      longint p;
      p = longint'(d) * longint'(g[11:0]) * (longint'(1) << g[15:12]) + longint'(32768);
      p = p >>> 16;
      sat = (p > 32767) || (p < -32768);
      r = p > 32767 ? 32767 : p < -32768 ? -32768 : int'(p);
   endfunction

   task automatic run_pair(input int dx, input int dy, input logic [15:0] g,
                           output int ox, output int oy, output logic of, output int lat);
      dix = dx[19:0];
      diy = dy[19:0];
      gain = g;
      iv = 1'b1;
      tick;
      iv = 1'b0;
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         tick;
         if (ov === 1'b1) begin
            lat = i;
            break;
         end
      end
      ox = dox;
      oy = doy;
      of = ovf;
   endtask

   task automatic test_reset;
      int n_ov;
      rst = 1'b1;
      iv = 1'b0;
      repeat (2) tick;
      n_cmp++; if ({dox, doy} !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", {dox, doy}); end
      n_cmp++; if ({ov, ovf, rdy} !== 3'b001) begin n_bad++; $display("FAIL reset_flags ov/ovf/rdy got %b want 001", {ov, ovf, rdy}); end
      rst = 1'b0;
      tick;
      n_cmp++; if (rdy !== 1'b1 || ov !== 1'b0) begin n_bad++; $display("FAIL idle rdy/ov got %b%b want 10", rdy, ov); end
      dix = 20'sd5000;
      diy = -20'sd5000;
      gain = 16'h1800;
      iv = 1'b1;
      tick;
      iv = 1'b0;
      tick;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL abort_rdy got %b want 1", rdy); end
      tick;
      rst = 1'b0;
      n_ov = 0;
      repeat (6) begin
         tick;
         if (ov === 1'b1) n_ov++;
      end
      n_cmp++; if (n_ov !== 0) begin n_bad++; $display("FAIL abort_no_ov got %0d pulses want 0", n_ov); end
      n_cmp++; if (dox !== 16'sd0 || doy !== 16'sd0) begin n_bad++; $display("FAIL abort_data got %0d/%0d want 0/0", dox, doy); end
   endtask

   task automatic test_unity;
      int ox, oy, lat;
      logic of;
      run_pair(4096, -4096, 16'h1800, ox, oy, of, lat);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL unity_latency got %0d want 3", lat); end
      n_cmp++; if (ox !== 256 || oy !== -256) begin n_bad++; $display("FAIL unity_data got %0d/%0d want 256/-256", ox, oy); end
      n_cmp++; if (of !== 1'b0) begin n_bad++; $display("FAIL unity_ovf got %b want 0", of); end
      tick;
      n_cmp++; if (ov !== 1'b0 || dox !== 16'sd256) begin n_bad++; $display("FAIL unity_pulse ov/dox got %b/%0d want 0/256", ov, dox); end
   endtask

   task automatic test_rounding;
      int ox, oy, lat;
      logic of;
      run_pair(1, -1, 16'h4800, ox, oy, of, lat);
      n_cmp++; if (ox !== 1 || oy !== 0) begin n_bad++; $display("FAIL round_e4 got %0d/%0d want 1/0", ox, oy); end
      run_pair(1, -1, 16'h3800, ox, oy, of, lat);
      n_cmp++; if (ox !== 0 || oy !== 0) begin n_bad++; $display("FAIL round_e3 got %0d/%0d want 0/0", ox, oy); end
   endtask

   task automatic test_max_gain;
      int ox, oy, lat;
      logic of;
      run_pair(1, -1, 16'hF800, ox, oy, of, lat);
      n_cmp++; if (ox !== 1024 || oy !== -1024 || of !== 1'b0) begin n_bad++; $display("FAIL maxgain_small got %0d/%0d ovf %b want 1024/-1024 ovf 0", ox, oy, of); end
      run_pair(65536, -65536, 16'hFFFF, ox, oy, of, lat);
      n_cmp++; if (ox !== 32767 || oy !== -32768) begin n_bad++; $display("FAIL sat_data got %0d/%0d want 32767/-32768", ox, oy); end
      n_cmp++; if (of !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b want 1", of); end
      repeat (2) tick;
      n_cmp++; if (ovf !== 1'b1 || dox !== 16'sd32767) begin n_bad++; $display("FAIL sat_hold ovf/dox got %b/%0d want 1/32767", ovf, dox); end
      run_pair(4096, -4096, 16'h1800, ox, oy, of, lat);
      n_cmp++; if (of !== 1'b0 || ox !== 256) begin n_bad++; $display("FAIL ovf_clear got ovf %b dox %0d want 0/256", of, ox); end
   endtask

   task automatic test_sweep;
      int ox, oy, lat, ex, ey;
      logic of;
      bit sx, sy;
      logic [15:0] g;
      for (int k = 0; k < 32; k++) begin
         g = 16'(k * 2048);
         run_pair(1000, -3, g, ox, oy, of, lat);
         ref_iq(1000, g, ex, sx);
         ref_iq(-3, g, ey, sy);
         n_cmp++; if (ox !== ex || oy !== ey || of !== (sx | sy)) begin n_bad++; $display("FAIL sweep_%0d got %0d/%0d ovf %b want %0d/%0d ovf %b", k, ox, oy, of, ex, ey, sx | sy); end
         if (g[11:0] == 12'd0) begin
            n_cmp++; if (ox !== 0 || oy !== 0 || of !== 1'b0) begin n_bad++; $display("FAIL mute_%0d got %0d/%0d ovf %b want 0/0 ovf 0", k, ox, oy, of); end
         end
      end
   endtask

   task automatic test_handshake;
      int qx[$], qy[$];
      int ex, ey, d;
      bit s;
      logic [15:0] g;
      for (int i = 0; i < 12; i++) begin
         n_cmp++; if (rdy !== (i % 4 == 0)) begin n_bad++; $display("FAIL hs_rdy_%0d got %b want %b", i, rdy, i % 4 == 0); end
         dix = 20'(i * 1000 + 77);
         diy = 20'(-(i * 700) - 5);
         gain = 16'(16'h2A00 + i * 16'h0111);
         iv = 1'b1;
         tick;
         if (ov === 1'b1) begin qx.push_back(int'(dox)); qy.push_back(int'(doy)); end
      end
      iv = 1'b0;
      repeat (6) begin
         tick;
         if (ov === 1'b1) begin qx.push_back(int'(dox)); qy.push_back(int'(doy)); end
      end
      n_cmp++; if (qx.size() !== 3) begin n_bad++; $display("FAIL hs_count got %0d want 3", qx.size()); end
      for (int j = 0; j < 3; j++) begin
         if (j < qx.size()) begin
            d = j * 4;
            g = 16'(16'h2A00 + d * 16'h0111);
            ref_iq(d * 1000 + 77, g, ex, s);
            ref_iq(-(d * 700) - 5, g, ey, s);
            n_cmp++; if (qx[j] !== ex || qy[j] !== ey) begin n_bad++; $display("FAIL hs_pair_%0d got %0d/%0d want %0d/%0d", j, qx[j], qy[j], ex, ey); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_unity;
      test_rounding;
      test_max_gain;
      test_sweep;
      test_handshake;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/logmul_iq_sat.md
# logmul_iq_sat

Parametrised I/Q gain scaler and successor to the fixed 20-in/16-out gain multiplier. It scales a complex sample pair (dix, diy) by a floating-point gain: an EW-bit exponent with an MW-bit fractional mantissa. It rounds and saturates the result to OW bits and flags saturation. It sits between the wide DSP datapath and the narrower output stages, and time-shares one multiplier between the X and Y channels under a small state machine.

## Interface
- DW, 20, input sample width (signed)
- OW, 16, output sample width (signed); constraint 2 ≤ OW < DW+MW
- EW, 4, gain exponent width (unsigned, E = 0..2^EW-1)
- MW, 12, gain mantissa width (unsigned fraction M/2^MW, nominal 0.5–1)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- dix, diy  in  DW  signed I/Q input samples
- iv  in  1  input valid strobe; sampled only while rdy=1
- gain  in  EW+MW  {E[EW-1:0], M[MW-1:0]}; captured together with the samples
- dox, doy  out  OW  signed scaled outputs, held between updates
- ov  out  1  output valid, one-cycle pulse
- ovf  out  1  at least one of dox/doy saturated; valid with ov, held until next ov
- rdy  out  1  block idle and able to accept iv

## Operation
- Per channel: p = d·M (signed, DW+MW+1 bits), s = p <<< E (DW+MW+2^EW bits), r = (s + 2^(K-1)) >>> K with K = DW+MW-OW. This is round-half-up, arithmetic shift.
- Saturation: r > 2^(OW-1)-1 gives 2^(OW-1)-1. r < -2^(OW-1) gives -2^(OW-1). Either clamp in X or Y sets ovf for that pair.
- M = 0 mutes: outputs 0, ovf 0. M < 0.5 is used as-is, with no normalisation.
- Gain is latched only on an accepted iv. Gain changes between samples never affect an in-flight pair.
- One multiplier is shared between X and Y: the X product is formed in MULX, the Y product in MULY.
- FSM states:
  - IDLE: rdy=1; iv=1 captures dix, diy, gain and moves to MULX.
  - MULX: registers the X product and moves to MULY.
  - MULY: registers the Y product and X shift/round/sat, then moves to RND.
  - RND: Y shift/round/sat; dox, doy, ovf are loaded and ov=1 at the same edge; moves to IDLE.
- iv while rdy=0 is ignored. The sample is dropped, with no queuing and no effect on the current pair.
- rst at any time returns to IDLE, aborts any in-flight pair, and produces no ov for it.

## Timing
- Reset values: dox=0, doy=0, ov=0, ovf=0, rdy=1; FSM=IDLE; internal registers 0.
- Latency: iv accepted at edge t0, then ov=1 with the new dox/doy/ovf in the cycle after edge t0+3. That is 3 clocks from the accepting edge to valid outputs.
- rdy is registered: it is low in the cycles after edges t0, t0+1, t0+2, and high again after t0+3.
- Throughput: one pair per 4 clocks. iv held continuously high is accepted every 4th edge.
- ov and rdy rise on the same edge. An iv presented in that cycle is accepted, so back-to-back pairs are spaced exactly 4 clocks.
- dox/doy/ovf change only on the ov edge or on rst.

## Test plan
- Reset, then check idle: rst pulse → dox=doy=0, ov=0, ovf=0, rdy=1. Assert rst during MULY → no ov follows and rdy=1 immediately.
- Unity-style scaling: dix=4096, diy=-4096, gain=0x1800 (E=1, M=0x800) → dox=256, doy=-256, ovf=0, ov exactly 3 clocks after the accepting edge.
- Rounding boundary: dix=1, diy=-1, gain=0x4800 (E=4, M=0x800) → dox=1, doy=0. With gain=0x3800 → dox=0, doy=0.
- Max gain / small input: dix=1, diy=-1, gain=0xF800 → dox=1024, doy=-1024. Then dix=65536, diy=-65536, gain=0xFFFF → dox=32767, doy=-32768, ovf=1. The next in-range pair clears ovf.
- Mute and gain sweep: gain stepped by 2048 over 32 pairs, mirroring the existing bench → each M=0 step gives 0/0. Every result matches the reference formula.
- Handshake: iv held high for 12 clocks with changing data and gain → exactly 3 pairs accepted, each using the gain present at its own accept edge. The intermediate samples are dropped, and no ov occurs without a preceding accept.
